// File: rtl/activity_scan_ctrl_pkg.sv
// Shared types and constants for the activity scan controller.
package actmon_pkg;

  localparam int ACT_W   = 16;
  localparam int LEVEL_W = 8;

  // Scheduler states; exported on the dbg_state port of the top.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARB    = 2'd1,
    ACCUM  = 2'd2,
    REPORT = 2'd3
  } state_t;

endpackage

// File: rtl/activity_scan_ctrl_if.sv
// Report channel from the scan controller to the level consumer.
//
// Handshake: the master raises out_valid with out_ch/out_level/out_peak and
// holds all of them stable until a cycle where out_valid && out_ready; that
// cycle is the transfer. out_valid never depends on out_ready.
interface activity_scan_ctrl_if #(
  parameter int N_CH = 4
);
  import actmon_pkg::*;

  logic                      out_valid;
  logic                      out_ready;
  logic [$clog2(N_CH)-1:0]   out_ch;
  logic [LEVEL_W-1:0]        out_level;
  logic [LEVEL_W-1:0]        out_peak;

  modport master (
    output out_valid, out_ch, out_level, out_peak,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_ch, out_level, out_peak,
    output out_ready
  );

endinterface

// File: rtl/activity_scan_ctrl_rr_arbiter.sv
// Combinational round-robin pick: first requester after last_grant, wrapping.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last_grant,
  output logic [$clog2(N)-1:0] gnt_idx,
  output logic                 gnt_any
);

  localparam int IW = $clog2(N);

  int idx;

  // Walk the channels starting one past the previous winner; first hit wins.
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = 0;
    for (int i = 1; i <= N; i++) begin
      idx = int'(last_grant) + i;
      if (idx >= N) idx = idx - N;
      if (!gnt_any && req[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/activity_scan_ctrl.sv
// Time-multiplexed activity monitor: grants channels round-robin, averages
// the granted channel over 2**WIN_LOG2 cycles and reports the upper byte.
// Optional build macro ACTMON_PEAK_EN adds a per-window peak of activity[15:8].
module activity_scan_ctrl
  import actmon_pkg::*;
#(
  parameter int N_CH     = 4,
  parameter int WIN_LOG2 = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [N_CH-1:0]         ch_req,
  input  logic [ACT_W*N_CH-1:0]   activity,
  activity_scan_ctrl_if.master    rpt,
  output logic                    busy,
  output state_t                  dbg_state
);

  localparam int CH_W  = $clog2(N_CH);
  localparam int ACC_W = ACT_W + WIN_LOG2;

  state_t              state, state_nxt;
  logic [CH_W-1:0]     sel;
  logic [CH_W-1:0]     last_grant;
  logic [ACC_W-1:0]    acc;
  logic [ACC_W-1:0]    acc_sum;
  logic [WIN_LOG2-1:0] cnt;
  logic                win_last;
  logic [ACT_W-1:0]    act_sel;
  logic [CH_W-1:0]     gnt_idx;
  logic                gnt_any;
  logic                new_req;

  rr_arbiter #(.N(N_CH)) u_arb (
    .req        (ch_req),
    .last_grant (last_grant),
    .gnt_idx    (gnt_idx),
    .gnt_any    (gnt_any)
  );

  assign act_sel  = activity[ACT_W*sel +: ACT_W];
  assign acc_sum  = acc + ACC_W'(act_sel);
  assign win_last = &cnt;
  assign new_req  = enable && (|ch_req);

  assign rpt.out_valid = (state == REPORT);
  assign busy          = (state != IDLE);
  assign dbg_state     = state;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; ARB falls back to IDLE if requests vanished.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (new_req) state_nxt = ARB;
      ARB:     state_nxt = gnt_any ? ACCUM : IDLE;
      ACCUM:   if (win_last) state_nxt = REPORT;
      REPORT:  if (rpt.out_ready) state_nxt = new_req ? ARB : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grant latch, window accumulation and level/channel report registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel           <= '0;
      last_grant    <= CH_W'(N_CH - 1);
      acc           <= '0;
      cnt           <= '0;
      rpt.out_ch    <= '0;
      rpt.out_level <= '0;
    end else begin
      case (state)
        ARB: begin
          if (gnt_any) begin
            sel        <= gnt_idx;
            last_grant <= gnt_idx;
          end
          acc <= '0;
          cnt <= '0;
        end
        ACCUM: begin
          acc <= acc_sum;
          cnt <= cnt + 1'b1;
          if (win_last) begin
            rpt.out_ch    <= sel;
            // Upper byte of sum / W: a plain truncating shift.
            rpt.out_level <= acc_sum[ACT_W-1+WIN_LOG2 -: LEVEL_W];
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ACTMON_PEAK_EN
  logic [LEVEL_W-1:0] peak;
  logic [LEVEL_W-1:0] peak_nxt;

  assign peak_nxt = (act_sel[ACT_W-1 -: LEVEL_W] > peak) ? act_sel[ACT_W-1 -: LEVEL_W] : peak;

  // Running maximum of the high byte, captured alongside the level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      peak         <= '0;
      rpt.out_peak <= '0;
    end else begin
      case (state)
        ARB:   peak <= '0;
        ACCUM: begin
          peak <= peak_nxt;
          if (win_last) rpt.out_peak <= peak_nxt;
        end
        default: ;
      endcase
    end
  end
`else
  assign rpt.out_peak = '0;
`endif

endmodule

// File: tb/tb_activity_scan_ctrl.sv
// Directed bench for activity_scan_ctrl (defaults N_CH=4, WIN_LOG2=3).
module tb_activity_scan_ctrl;
  import actmon_pkg::*;

`ifdef ACTMON_PEAK_EN
  localparam bit PEAK = 1'b1;
`else
  localparam bit PEAK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [3:0]  ch_req;
  logic [63:0] activity;
  logic        busy;
  state_t      dbg_state;
  logic        alt_en;

  int tests_run    = 0;
  int tests_failed = 0;

  activity_scan_ctrl_if #(.N_CH(4)) rpt ();

  activity_scan_ctrl #(.N_CH(4), .WIN_LOG2(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .ch_req    (ch_req),
    .activity  (activity),
    .rpt       (rpt),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // Clock.
  always #5 clk = ~clk;

  // One cycle: wait the edge, settle, then optionally toggle channel 2 data.
  task tick;
    @(posedge clk);
    #1;
    if (alt_en) activity[47:32] = ~activity[47:32];
  endtask

  task apply_reset;
    reset = 1'b1; enable = 1'b0; ch_req = '0; activity = '0;
    rpt.out_ready = 1'b0; alt_en = 1'b0;
    tick; tick;
    reset = 1'b0;
    tick;
  endtask

  task wait_arb(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (dbg_state == ARB) begin ok = 1'b1; break; end
    end
  endtask

  // Returns cycles elapsed until out_valid is seen, 0 on timeout.
  task wait_valid(output int n);
    n = 0;
    for (int i = 1; i <= 30; i++) begin
      tick;
      if (rpt.out_valid) begin n = i; break; end
    end
  endtask

  task test_reset;
    apply_reset;
    tests_run++;
    if (rpt.out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got %b want 0", rpt.out_valid); end
    tests_run++;
    if (rpt.out_ch !== 2'd0) begin tests_failed++; $display("FAIL reset_ch got %0d want 0", rpt.out_ch); end
    tests_run++;
    if (rpt.out_level !== 8'h00 || rpt.out_peak !== 8'h00) begin
      tests_failed++; $display("FAIL reset_level_peak got %h/%h want 00/00", rpt.out_level, rpt.out_peak);
    end
    tests_run++;
    if (busy !== 1'b0 || dbg_state !== IDLE) begin
      tests_failed++; $display("FAIL reset_state got busy=%b st=%0d want 0/IDLE", busy, dbg_state);
    end
  endtask

  // Channel 1 only, constant 0x3456; then hold off the consumer for 5 cycles.
  task test_single_and_hold;
    bit ok;
    int n;
    enable = 1'b1; activity[31:16] = 16'h3456; ch_req = 4'b0010;
    wait_arb(ok);
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL single_arb timeout"); end
    wait_valid(n);
    tests_run++;
    if (n !== 9) begin tests_failed++; $display("FAIL single_latency got %0d want 9", n); end
    tests_run++;
    if (rpt.out_ch !== 2'd1) begin tests_failed++; $display("FAIL single_ch got %0d want 1", rpt.out_ch); end
    tests_run++;
    if (rpt.out_level !== 8'h34) begin tests_failed++; $display("FAIL single_level got %h want 34", rpt.out_level); end
    tests_run++;
    if (rpt.out_peak !== (PEAK ? 8'h34 : 8'h00)) begin
      tests_failed++; $display("FAIL single_peak got %h want %h", rpt.out_peak, PEAK ? 8'h34 : 8'h00);
    end
    activity[31:16] = 16'hFFFF;
    for (int i = 0; i < 5; i++) begin
      tick;
      tests_run++;
      if (rpt.out_valid !== 1'b1 || rpt.out_ch !== 2'd1 || rpt.out_level !== 8'h34 ||
          busy !== 1'b1 || dbg_state !== REPORT) begin
        tests_failed++;
        $display("FAIL hold_stable cyc %0d got v=%b ch=%0d lvl=%h busy=%b st=%0d want 1/1/34/1/REPORT",
                 i, rpt.out_valid, rpt.out_ch, rpt.out_level, busy, dbg_state);
      end
    end
    ch_req = '0; rpt.out_ready = 1'b1;
    tick;
    rpt.out_ready = 1'b0;
    tests_run++;
    if (dbg_state !== IDLE || busy !== 1'b0 || rpt.out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL hold_accept got st=%0d busy=%b v=%b want IDLE/0/0", dbg_state, busy, rpt.out_valid);
    end
  endtask

  // Channel 2 alternating 0x0000/0xFFFF: sum 0x3FFFC, level 0x7F.
  task test_alternate;
    bit ok;
    int n;
    activity = '0; ch_req = 4'b0100; alt_en = 1'b1;
    wait_arb(ok);
    wait_valid(n);
    alt_en = 1'b0;
    tests_run++;
    if (!ok || n !== 9) begin tests_failed++; $display("FAIL alt_timing got arb=%b n=%0d want 1/9", ok, n); end
    tests_run++;
    if (rpt.out_ch !== 2'd2) begin tests_failed++; $display("FAIL alt_ch got %0d want 2", rpt.out_ch); end
    tests_run++;
    if (rpt.out_level !== 8'h7F) begin tests_failed++; $display("FAIL alt_level got %h want 7f", rpt.out_level); end
    tests_run++;
    if (rpt.out_peak !== (PEAK ? 8'hFF : 8'h00)) begin
      tests_failed++; $display("FAIL alt_peak got %h want %h", rpt.out_peak, PEAK ? 8'hFF : 8'h00);
    end
    ch_req = '0; rpt.out_ready = 1'b1;
    tick;
    rpt.out_ready = 1'b0;
  endtask

  // All channels requesting, consumer always ready: 0,1,2,3,0 every 10 cycles.
  task test_back_to_back;
    int cyc[5];
    logic [1:0] chs[5];
    logic [7:0] lvls[5];
    logic [7:0] pks[5];
    int nrep;
    logic [7:0] exp_lvl;
    apply_reset;
    activity = {16'h4400, 16'h3300, 16'h2200, 16'h1100};
    enable = 1'b1; ch_req = 4'hF; rpt.out_ready = 1'b1;
    nrep = 0;
    for (int i = 1; i <= 80; i++) begin
      tick;
      if (rpt.out_valid) begin
        cyc[nrep] = i; chs[nrep] = rpt.out_ch; lvls[nrep] = rpt.out_level; pks[nrep] = rpt.out_peak;
        nrep++;
        if (nrep == 5) begin ch_req = '0; break; end
      end
    end
    tests_run++;
    if (nrep != 5) begin tests_failed++; $display("FAIL b2b_count got %0d want 5", nrep); end
    for (int k = 0; k < nrep; k++) begin
      exp_lvl = 8'((k % 4 + 1) * 8'h11);
      tests_run++;
      if (chs[k] !== 2'(k % 4) || lvls[k] !== exp_lvl || pks[k] !== (PEAK ? exp_lvl : 8'h00)) begin
        tests_failed++;
        $display("FAIL b2b_report %0d got ch=%0d lvl=%h pk=%h want ch=%0d lvl=%h", k, chs[k], lvls[k], pks[k], k % 4, exp_lvl);
      end
      if (k > 0) begin
        tests_run++;
        if (cyc[k] - cyc[k-1] != 10) begin
          tests_failed++; $display("FAIL b2b_spacing %0d got %0d want 10", k, cyc[k] - cyc[k-1]);
        end
      end
    end
    tick;
    rpt.out_ready = 1'b0;
    tests_run++;
    if (dbg_state !== IDLE) begin tests_failed++; $display("FAIL b2b_idle got st=%0d want IDLE", dbg_state); end
  endtask

  // Reset four cycles into ACCUM; the next grant restarts at channel 0.
  task test_reset_mid;
    bit ok;
    int n;
    ch_req = 4'b0100; enable = 1'b1;
    wait_arb(ok);
    for (int i = 0; i < 4; i++) tick;
    tests_run++;
    if (!ok || dbg_state !== ACCUM) begin tests_failed++; $display("FAIL rstmid_pre got arb=%b st=%0d want 1/ACCUM", ok, dbg_state); end
    reset = 1'b1;
    #1;
    tests_run++;
    if (rpt.out_valid !== 1'b0 || rpt.out_ch !== 2'd0 || rpt.out_level !== 8'h00 ||
        rpt.out_peak !== 8'h00 || busy !== 1'b0 || dbg_state !== IDLE) begin
      tests_failed++;
      $display("FAIL rstmid_clear got v=%b ch=%0d lvl=%h pk=%h busy=%b st=%0d want all 0/IDLE",
               rpt.out_valid, rpt.out_ch, rpt.out_level, rpt.out_peak, busy, dbg_state);
    end
    tick;
    reset = 1'b0; ch_req = 4'hF;
    wait_arb(ok);
    wait_valid(n);
    tests_run++;
    if (!ok || n !== 9 || rpt.out_ch !== 2'd0) begin
      tests_failed++; $display("FAIL rstmid_regrant got arb=%b n=%0d ch=%0d want 1/9/0", ok, n, rpt.out_ch);
    end
    ch_req = '0; rpt.out_ready = 1'b1;
    tick;
    rpt.out_ready = 1'b0;
  endtask

  // enable drops mid-window: report still arrives, then back to IDLE.
  task test_enable_drop;
    bit ok;
    int n;
    activity[63:48] = 16'h8000; ch_req = 4'b1000; enable = 1'b1;
    wait_arb(ok);
    tick; tick;
    enable = 1'b0;
    wait_valid(n);
    tests_run++;
    if (!ok || n == 0 || rpt.out_ch !== 2'd3 || rpt.out_level !== 8'h80) begin
      tests_failed++; $display("FAIL endrop_report got arb=%b n=%0d ch=%0d lvl=%h want 1/>0/3/80", ok, n, rpt.out_ch, rpt.out_level);
    end
    rpt.out_ready = 1'b1;
    tick;
    rpt.out_ready = 1'b0;
    tests_run++;
    if (dbg_state !== IDLE || busy !== 1'b0 || rpt.out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL endrop_idle got st=%0d busy=%b v=%b want IDLE/0/0", dbg_state, busy, rpt.out_valid);
    end
    tick; tick;
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL endrop_stay got busy=%b want 0", busy); end
  endtask

  initial begin
    test_reset;
    test_single_and_hold;
    test_alternate;
    test_back_to_back;
    test_reset_mid;
    test_enable_drop;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
